inst_loader: RTL and testbench
==============================

// Module: inst_loader
// PURPOSE
//  Front end of the bit-serial CPU: assembles a 16-bit instruction one bit per load-button press.
//  Presents it to the control FSM as opcode[3:0]/instr[11:0] with inst_done, and issues the
//  one-cycle btn_edge execute pulse. Holds the instruction stable until the FSM has executed it
//  and returned to idle, then rearms for the next instruction.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive equal synchronized samples needed to accept a button level
//  INSTR_W          16  instruction width in bits (opcode = low 4 bits); counter width = $clog2(INSTR_W)+1
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  rst          in   1   synchronous, active-high reset
//  ser_data_in  in   1   instruction bit to capture (switch input, async)
//  load_btn     in   1   raw push-button: capture ser_data_in (async, bouncy)
//  exec_btn     in   1   raw push-button: execute loaded instruction (async, bouncy)
//  fsm_idle     in   1   high while control FSM is in its IDLE state
//  opcode       out  4   shreg[3:0]
//  instr        out  12  shreg[15:4]
//  inst_done    out  1   all INSTR_W bits captured; instruction valid
//  btn_edge     out  1   one-cycle execute pulse to control FSM
//  bit_cnt      out  5   bits captured so far (0..16), for LED display
// BEHAVIOUR
//  Reset (rst high at posedge): shreg=0, bit_cnt=0, inst_done=0, btn_edge=0, state=S_LOAD,
//   synchronizers/debounce counters=0, debounced levels=0. Reset wins over every other event,
//   including mid-load and mid-execute.
//  Input conditioning (per button): 2-flop synchronizer -> debounce. Debounced level updates
//   only after DEBOUNCE_CYCLES consecutive cycles of synchronized value != current level;
//   any mismatch-run break resets the count. A rising edge of the debounced level gives a
//   one-cycle internal pulse (load_p / exec_p). ser_data_in: 2-flop synchronized only, sampled
//   in the same cycle load_p is high. Min latency raw press -> pulse = 2 + DEBOUNCE_CYCLES cycles.
//  Capture: LSB first. On load_p in S_LOAD: shreg <= {ser_bit, shreg[15:1]}, bit_cnt++.
//   After 16 captures, the first bit captured is shreg[0].
//  States:
//   S_LOAD  : inst_done=0. load_p captures. When capture makes bit_cnt==16 -> S_READY
//             (inst_done=1 the following cycle). exec_p ignored.
//   S_READY : inst_done=1; shreg frozen; load_p ignored. exec_p && fsm_idle -> S_ISSUE.
//             exec_p with fsm_idle=0 is dropped, not queued.
//   S_ISSUE : btn_edge=1 for exactly this one cycle; inst_done stays 1 -> S_BUSY.
//   S_BUSY  : wait for fsm_idle==0 -> S_DRAIN. btn_edge=0; shreg frozen.
//   S_DRAIN : wait for fsm_idle==1 -> S_LOAD, bit_cnt=0, inst_done=0.
//             shreg is not cleared; it is overwritten by new captures.
//  opcode/instr are combinational slices of shreg and are stable from S_READY through S_DRAIN.
//  btn_edge and inst_done are registered; the FSM samples both in the same cycle.
//  Simultaneous load_p and exec_p: the state decides (S_LOAD takes load, S_READY takes exec).
//  bit_cnt saturates at 16 and never wraps; load_p outside S_LOAD never changes shreg/bit_cnt.
//  Held buttons produce one pulse per press (edge, not level).
// TESTING (DEBOUNCE_CYCLES=4)
//  1. Reset, press load 16x with bits of 0xA5C3 (LSB first) -> opcode=4'h3, instr=12'hA5C,
//     inst_done=1, bit_cnt=16.
//  2. Loaded, fsm_idle=1, press exec -> btn_edge high exactly 1 cycle, 6-7 cycles after the raw
//     rise. Drive fsm_idle 0 for 20 cycles, then 1 -> inst_done=0 and bit_cnt=0 one cycle later.
//  3. Bounce load_btn 1/0 every 2 cycles for 20 cycles, then hold high -> exactly one capture.
//     Extra load presses in S_READY -> shreg unchanged.
//  4. Press exec at bit_cnt=9 -> no btn_edge.
//     Press exec when loaded with fsm_idle=0 -> no btn_edge, stays S_READY.
//  5. Assert rst mid-load (bit_cnt=7) and in S_BUSY -> all outputs 0 next cycle.
//     Then a full reload of 0x1234 -> opcode=4, instr=12'h123.
//  6. Hold load_btn high 100 cycles -> bit_cnt increments by 1 only.

Source files
------------

// File: rtl/inst_loader.sv
// inst_loader: bit-serial instruction assembler for the bit-serial CPU front end.
// Two debounced push-buttons (load/exec) plus a synchronized serial data switch
// build a 16-bit instruction LSB first, then hand it to the control FSM with a
// one-cycle execute pulse and hold it until the FSM has returned to idle.
module inst_loader #(
   parameter int  DEBOUNCE_CYCLES = 4,
   parameter int  INSTR_W         = 16,
   localparam int CNT_W           = $clog2(INSTR_W) + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ser_data_in,
   input  logic               load_btn,
   input  logic               exec_btn,
   input  logic               fsm_idle,
   output logic [3:0]         opcode,
   output logic [INSTR_W-5:0] instr,
   output logic               inst_done,
   output logic               btn_edge,
   output logic [CNT_W-1:0]   bit_cnt
);

   localparam int             DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] FULL   = CNT_W'(INSTR_W);

   typedef enum logic [2:0] {
      S_LOAD,
      S_READY,
      S_ISSUE,
      S_BUSY,
      S_DRAIN
   } state_t;

   // Button index 0 = load, 1 = exec.
   logic [1:0] raw_btn;
   logic [1:0] btn_pulse;
   logic       load_p;
   logic       exec_p;

   assign raw_btn = {exec_btn, load_btn};
   assign load_p  = btn_pulse[0];
   assign exec_p  = btn_pulse[1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         logic            sync1_reg;
         logic            sync2_reg;
         logic            level_reg;
         logic            pulse_reg;
         logic [DB_W-1:0] db_cnt_reg;

         // Synchronize, require a full run of differing samples to flip the
         // level, and emit a single-cycle pulse on each accepted rising level.
         always_ff @(posedge clk) begin
            if (rst) begin
               sync1_reg  <= 1'b0;
               sync2_reg  <= 1'b0;
               level_reg  <= 1'b0;
               pulse_reg  <= 1'b0;
               db_cnt_reg <= '0;
            end else begin
               sync1_reg <= raw_btn[gi];
               sync2_reg <= sync1_reg;
               pulse_reg <= 1'b0;
               if (sync2_reg != level_reg) begin
                  if (db_cnt_reg == DB_LAST) begin
                     level_reg  <= sync2_reg;
                     pulse_reg  <= sync2_reg;
                     db_cnt_reg <= '0;
                  end else begin
                     db_cnt_reg <= db_cnt_reg + DB_W'(1);
                  end
               end else begin
                  db_cnt_reg <= '0;
               end
            end
         end

         assign btn_pulse[gi] = pulse_reg;
      end
   endgenerate

   // Serial data is a slow switch: synchronize only, its value is taken
   // in the same cycle the load pulse is seen.
   logic ser_sync1_reg;
   logic ser_sync2_reg;

   // Two-flop synchronizer for the serial data switch.
   always_ff @(posedge clk) begin
      if (rst) begin
         ser_sync1_reg <= 1'b0;
         ser_sync2_reg <= 1'b0;
      end else begin
         ser_sync1_reg <= ser_data_in;
         ser_sync2_reg <= ser_sync1_reg;
      end
   end

   state_t             state_reg;
   logic [INSTR_W-1:0] shreg_reg;
   logic [CNT_W-1:0]   bit_cnt_reg;
   logic               inst_done_reg;
   logic               btn_edge_reg;

   // Load/issue handshake FSM with registered inst_done and btn_edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_LOAD;
         shreg_reg     <= '0;
         bit_cnt_reg   <= '0;
         inst_done_reg <= 1'b0;
         btn_edge_reg  <= 1'b0;
      end else begin
         case (state_reg)
            S_LOAD: begin
               inst_done_reg <= 1'b0;
               btn_edge_reg  <= 1'b0;
               if (load_p && (bit_cnt_reg != FULL)) begin
                  shreg_reg   <= {ser_sync2_reg, shreg_reg[INSTR_W-1:1]};
                  bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                  if (bit_cnt_reg == FULL - CNT_W'(1)) begin
                     state_reg     <= S_READY;
                     inst_done_reg <= 1'b1;
                  end
               end
            end
            S_READY: begin
               // An exec press while the FSM is busy is dropped, not queued.
               if (exec_p && fsm_idle) begin
                  state_reg    <= S_ISSUE;
                  btn_edge_reg <= 1'b1;
               end
            end
            S_ISSUE: begin
               btn_edge_reg <= 1'b0;
               state_reg    <= S_BUSY;
            end
            S_BUSY: begin
               if (!fsm_idle) begin
                  state_reg <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // shreg is left as-is; new captures shift the old bits out.
               if (fsm_idle) begin
                  state_reg     <= S_LOAD;
                  bit_cnt_reg   <= '0;
                  inst_done_reg <= 1'b0;
               end
            end
            default: begin
               state_reg <= S_LOAD;
            end
         endcase
      end
   end

   assign opcode    = shreg_reg[3:0];
   assign instr     = shreg_reg[INSTR_W-1:4];
   assign inst_done = inst_done_reg;
   assign btn_edge  = btn_edge_reg;
   assign bit_cnt   = bit_cnt_reg;

endmodule

// File: tb/tb_inst_loader.sv
// Testbench for inst_loader: directed button sequences checked every cycle
// against a sample-history model, plus hand-computed literal expectations.
module tb_inst_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ser_data_in = 1'b0;
   logic        load_btn = 1'b0;
   logic        exec_btn = 1'b0;
   logic        fsm_idle = 1'b1;
   logic [3:0]  opcode;
   logic [11:0] instr;
   logic        inst_done;
   logic        btn_edge;
   logic [4:0]  bit_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int edge_cnt  = 0;
   bit chk_en    = 1'b0;

   inst_loader #(.DEBOUNCE_CYCLES(4), .INSTR_W(16)) dut (
      .clk(clk), .rst(rst), .ser_data_in(ser_data_in), .load_btn(load_btn),
      .exec_btn(exec_btn), .fsm_idle(fsm_idle), .opcode(opcode), .instr(instr),
      .inst_done(inst_done), .btn_edge(btn_edge), .bit_cnt(bit_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Buttons: the debounced level follows the synchronized input once the last
   // four synchronized samples all disagree with it; synchronized = raw two
   // clocks ago. A rising level acts on the instruction one clock later.
   localparam int M_LOAD = 0, M_READY = 1, M_ISSUE = 2, M_BUSY = 3, M_DRAIN = 4;
   int          m_state = M_LOAD;
   logic [15:0] m_sh    = '0;
   int          m_cnt   = 0;
   bit          m_done  = 0;
   bit          m_edge  = 0;
   bit          raw_h [0:1][0:1];
   bit          smp_h [0:1][0:3];
   bit          lvl   [0:1];
   bit          pul   [0:1];
   bit          ser_h [0:1];
   bit          ser_s, s_now, all_diff, raw_now;

   always @(posedge clk) begin
      if (rst) begin
         m_state = M_LOAD; m_sh = '0; m_cnt = 0; m_done = 0; m_edge = 0;
         ser_h[0] = 0; ser_h[1] = 0;
         for (int b = 0; b < 2; b++) begin
            lvl[b] = 0; pul[b] = 0; raw_h[b][0] = 0; raw_h[b][1] = 0;
            for (int k = 0; k < 4; k++) smp_h[b][k] = 0;
         end
      end else begin
         ser_s = ser_h[1];
         case (m_state)
            M_LOAD:  if (pul[0] && m_cnt < 16) begin
                        m_sh  = (m_sh >> 1) | (16'(ser_s) << 15);
                        m_cnt = m_cnt + 1;
                        if (m_cnt == 16) begin m_state = M_READY; m_done = 1; end
                     end
            M_READY: if (pul[1] && fsm_idle) begin m_state = M_ISSUE; m_edge = 1; end
            M_ISSUE: begin m_edge = 0; m_state = M_BUSY; end
            M_BUSY:  if (!fsm_idle) m_state = M_DRAIN;
            default: if (fsm_idle) begin m_state = M_LOAD; m_cnt = 0; m_done = 0; end
         endcase
         ser_h[1] = ser_h[0]; ser_h[0] = ser_data_in;
         for (int b = 0; b < 2; b++) begin
            raw_now = (b == 0) ? load_btn : exec_btn;
            s_now = raw_h[b][1];
            raw_h[b][1] = raw_h[b][0]; raw_h[b][0] = raw_now;
            for (int k = 3; k > 0; k--) smp_h[b][k] = smp_h[b][k-1];
            smp_h[b][0] = s_now;
            all_diff = 1;
            for (int k = 0; k < 4; k++) if (smp_h[b][k] == lvl[b]) all_diff = 0;
            pul[b] = 0;
            if (all_diff) begin lvl[b] = s_now; pul[b] = s_now; end
         end
      end
   end

   // Per-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      if (btn_edge) edge_cnt++;
      if (chk_en) begin
         chk("cyc_opcode", opcode, m_sh[3:0]);
         chk("cyc_instr", instr, m_sh[15:4]);
         chk("cyc_inst_done", inst_done, m_done);
         chk("cyc_btn_edge", btn_edge, m_edge);
         chk("cyc_bit_cnt", bit_cnt, m_cnt);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic press_load(input bit v);
      ser_data_in = v; load_btn = 1; tick(10); load_btn = 0; tick(10);
   endtask

   task automatic press_exec();
      exec_btn = 1; tick(10); exec_btn = 0; tick(10);
   endtask

   task automatic load_word(input logic [15:0] w, input int from, input int to);
      for (int i = from; i < to; i++) press_load(w[i]);
   endtask

   task automatic drain();
      fsm_idle = 1; press_exec(); fsm_idle = 0; tick(3); fsm_idle = 1; tick(2);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_opcode"}, opcode, 0);
      chk({tag, "_instr"}, instr, 0);
      chk({tag, "_done"}, inst_done, 0);
      chk({tag, "_edge"}, btn_edge, 0);
      chk({tag, "_cnt"}, bit_cnt, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      int n, e0;
      tick(3);
      chk_en = 1;
      chk_zero("reset");
      rst = 0;
      tick(2);

      // 1: load 0xA5C3
      load_word(16'hA5C3, 0, 16);
      chk("t1_opcode", opcode, 4'h3);
      chk("t1_instr", instr, 12'hA5C);
      chk("t1_done", inst_done, 1);
      chk("t1_cnt", bit_cnt, 16);
      $display("txn load 0xA5C3 opcode=%h instr=%h", opcode, instr);

      // 2: execute, measure latency, drain
      fsm_idle = 1;
      e0 = edge_cnt;
      exec_btn = 1;
      n = 0;
      while (n < 20) begin
         tick(1); n++;
         if (btn_edge) break;
      end
      chk("t2_latency_in_6_7", (n >= 6 && n <= 7) ? 1 : 0, 1);
      tick(1);
      chk("t2_edge_width", btn_edge, 0);
      tick(8); exec_btn = 0; tick(10);
      chk("t2_edge_count", edge_cnt - e0, 1);
      fsm_idle = 0; tick(20); fsm_idle = 1; tick(1);
      chk("t2_done_cleared", inst_done, 0);
      chk("t2_cnt_cleared", bit_cnt, 0);
      $display("txn exec latency=%0d cycles", n);

      // 3: bouncing load gives one capture; presses in READY ignored
      ser_data_in = 1;
      repeat (5) begin load_btn = 1; tick(2); load_btn = 0; tick(2); end
      load_btn = 1; tick(10); load_btn = 0; tick(10);
      chk("t3_bounce_cnt", bit_cnt, 1);
      load_word(16'h00FF, 1, 16);
      repeat (3) press_load(0);
      chk("t3_frozen_word", {instr, opcode}, 16'h00FF);
      chk("t3_frozen_cnt", bit_cnt, 16);
      $display("txn bounce+ready presses word=%h", {instr, opcode});

      // 4: exec dropped while FSM busy, and while still loading
      fsm_idle = 0;
      e0 = edge_cnt;
      press_exec();
      chk("t4_busy_no_edge", edge_cnt - e0, 0);
      chk("t4_stays_ready", inst_done, 1);
      drain();
      load_word(16'h01FF, 0, 9);
      e0 = edge_cnt;
      press_exec();
      chk("t4_partial_no_edge", edge_cnt - e0, 0);
      chk("t4_partial_cnt", bit_cnt, 9);
      $display("txn exec ignored cnt=%0d", bit_cnt);

      // 5: reset mid-load and in BUSY, then reload 0x1234
      rst = 1; tick(1); rst = 0;
      load_word(16'h007F, 0, 7);
      chk("t5_cnt7", bit_cnt, 7);
      rst = 1; tick(1);
      chk_zero("t5_rst_load");
      rst = 0;
      load_word(16'hA5C3, 0, 16);
      fsm_idle = 1; exec_btn = 1; tick(9);
      chk("t5_busy_done", inst_done, 1);
      rst = 1; tick(1);
      chk_zero("t5_rst_busy");
      rst = 0; exec_btn = 0; tick(10);
      load_word(16'h1234, 0, 16);
      chk("t5_opcode", opcode, 4'h4);
      chk("t5_instr", instr, 12'h123);
      chk("t5_done", inst_done, 1);
      $display("txn reload 0x1234 opcode=%h instr=%h", opcode, instr);

      // 6: held load button gives one capture
      drain();
      chk("t6_cnt_start", bit_cnt, 0);
      ser_data_in = 1; load_btn = 1; tick(100); load_btn = 0; tick(10);
      chk("t6_held_cnt", bit_cnt, 1);
      $display("txn held load cnt=%0d", bit_cnt);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
